register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 116 +++++++++++
 tb/tb_register_file.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with rename tags: 32 x 32-bit values, each with a
// busy bit and the ROB tag of its youngest in-flight writer, plus operand bypass.
module register_file #(
  parameter int unsigned ROB_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                commit_valid,
  input  logic [4:0]          commit_rd,
  input  logic [31:0]         commit_val,
  input  logic [ROB_BITS-1:0] commit_rob_id,
  input  logic                dep_valid,
  input  logic [4:0]          dep_rd,
  input  logic [ROB_BITS-1:0] dep_rob_id,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  output logic [ROB_BITS-1:0] need_rob_id1,
  output logic [ROB_BITS-1:0] need_rob_id2,
  input  logic                rob_value1_ready,
  input  logic                rob_value2_ready,
  input  logic [31:0]         rob_value1,
  input  logic [31:0]         rob_value2,
  output logic [31:0]         val1,
  output logic [31:0]         val2,
  output logic                dep1_busy,
  output logic                dep2_busy,
  output logic [ROB_BITS-1:0] dep1_rob_id,
  output logic [ROB_BITS-1:0] dep2_rob_id
);

  logic [31:0]         value_q [32];
  logic [31:0]         value_d [32];
  logic [31:0]         busy_q;
  logic [31:0]         busy_d;
  logic [ROB_BITS-1:0] tag_q   [32];
  logic [ROB_BITS-1:0] tag_d   [32];

  logic commit_en;
  logic dep_en;

  assign commit_en = rdy && commit_valid && (commit_rd != 5'd0);
  assign dep_en    = rdy && dep_valid && !clear && (dep_rd != 5'd0);

  // Commit is applied first so a same-cycle rename of the same rd overrides
  // busy/tag, while the committed value still lands.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (commit_en) begin
      value_d[commit_rd] = commit_val;
      if (tag_q[commit_rd] == commit_rob_id) begin
        busy_d[commit_rd] = 1'b0;
      end
    end
    if (rdy && clear) begin
      busy_d = '0;
    end
    if (dep_en) begin
      busy_d[dep_rd] = 1'b1;
      tag_d[dep_rd]  = dep_rob_id;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  // Returns {still_busy, operand}; bypass priority is commit bus, then ROB.
  function automatic logic [32:0] read_port(
    input logic [4:0]  rs,
    input logic        rob_ready,
    input logic [31:0] rob_value
  );
    logic [32:0] r;
    r = '0;
    if (rs == 5'd0) begin
      r = '0;
    end else if (!busy_q[rs]) begin
      r = {1'b0, value_q[rs]};
    end else if (commit_valid && (commit_rd == rs) && (commit_rob_id == tag_q[rs])) begin
      r = {1'b0, commit_val};
    end else if (rob_ready) begin
      r = {1'b0, rob_value};
    end else begin
      r = {1'b1, 32'd0};
    end
    return r;
  endfunction

  always_comb begin
    {dep1_busy, val1} = read_port(rs1, rob_value1_ready, rob_value1);
    need_rob_id1      = tag_q[rs1];
    dep1_rob_id       = tag_q[rs1];
  end

  always_comb begin
    {dep2_busy, val2} = read_port(rs2, rob_value2_ready, rob_value2);
    need_rob_id2      = tag_q[rs2];
    dep2_rob_id       = tag_q[rs2];
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed scenarios plus random traffic,
// checked against an array-based reference model of the register state.
module tb_register_file;
  localparam int RB = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, clear;
  logic          commit_valid, dep_valid;
  logic [4:0]    commit_rd, dep_rd, rs1, rs2;
  logic [31:0]   commit_val, rob_value1, rob_value2;
  logic [RB-1:0] commit_rob_id, dep_rob_id;
  logic          rob_value1_ready, rob_value2_ready;
  logic [RB-1:0] need_rob_id1, need_rob_id2, dep1_rob_id, dep2_rob_id;
  logic [31:0]   val1, val2;
  logic          dep1_busy, dep2_busy;

  register_file #(.ROB_BITS(RB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id),
    .dep_valid(dep_valid), .dep_rd(dep_rd), .dep_rob_id(dep_rob_id),
    .rs1(rs1), .rs2(rs2),
    .need_rob_id1(need_rob_id1), .need_rob_id2(need_rob_id2),
    .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
    .rob_value1(rob_value1), .rob_value2(rob_value2),
    .val1(val1), .val2(val2), .dep1_busy(dep1_busy), .dep2_busy(dep2_busy),
    .dep1_rob_id(dep1_rob_id), .dep2_rob_id(dep2_rob_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, rdy, clear;
    logic          cv;
    logic [4:0]    crd;
    logic [31:0]   cval;
    logic [RB-1:0] cid;
    logic          dv;
    logic [4:0]    drd;
    logic [RB-1:0] did;
    logic [4:0]    rs1, rs2;
    logic          rr1, rr2;
    logic [31:0]   rv1, rv2;
  } stim_t;

  typedef struct {
    string         name;
    logic [31:0]   v1, v2;
    logic          b1, b2;
    logic [RB-1:0] t1, t2;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  // Reference state: what the architectural file should hold.
  logic [31:0]   m_val  [32];
  bit            m_busy [32];
  logic [RB-1:0] m_tag  [32];
  stim_t         cur;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, rdy: 1'b1, clear: 1'b0, cv: 1'b0, crd: 5'd0, cval: 32'd0,
          cid: '0, dv: 1'b0, drd: 5'd0, did: '0, rs1: 5'd0, rs2: 5'd0,
          rr1: 1'b0, rr2: 1'b0, rv1: 32'd0, rv2: 32'd0};
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'd0; m_busy[i] = 0; m_tag[i] = '0;
    end
  endfunction

  // Effect of one clock edge under the inputs held in cur.
  function automatic void model_edge();
    bit commit_hits, do_dep;
    if (!cur.rst || !cur.rdy) return;
    commit_hits = cur.cv && cur.crd != 0;
    do_dep      = cur.dv && cur.drd != 0 && !cur.clear;
    if (commit_hits) m_val[cur.crd] = cur.cval;
    if (commit_hits && m_tag[cur.crd] == cur.cid && !(do_dep && cur.drd == cur.crd))
      m_busy[cur.crd] = 0;
    if (cur.clear)
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    if (do_dep) begin
      m_busy[cur.drd] = 1;
      m_tag[cur.drd]  = cur.did;
    end
  endfunction

  function automatic void model_read(input logic [4:0] rs, input logic rr, input logic [31:0] rv,
                                     output logic [31:0] v, output logic b, output logic [RB-1:0] t);
    t = m_tag[rs];
    v = 32'd0;
    b = 1'b0;
    if (rs == 0) return;
    if (!m_busy[rs])                                          v = m_val[rs];
    else if (cur.cv && cur.crd == rs && cur.cid == m_tag[rs]) v = cur.cval;
    else if (rr)                                              v = rv;
    else                                                      b = 1'b1;
  endfunction

  task automatic apply(input stim_t s, input string name);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    cur = s;
    rst = s.rst; rdy = s.rdy; clear = s.clear;
    commit_valid = s.cv; commit_rd = s.crd; commit_val = s.cval; commit_rob_id = s.cid;
    dep_valid = s.dv; dep_rd = s.drd; dep_rob_id = s.did;
    rs1 = s.rs1; rs2 = s.rs2;
    rob_value1_ready = s.rr1; rob_value2_ready = s.rr2;
    rob_value1 = s.rv1; rob_value2 = s.rv2;
    if (!s.rst) model_reset();
    e.name = name;
    model_read(s.rs1, s.rr1, s.rv1, e.v1, e.b1, e.t1);
    model_read(s.rs2, s.rr2, s.rv2, e.v2, e.b2, e.t2);
    exp_q.push_back(e);
  endtask

  // Monitor: combinational outputs are sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (val1 !== e.v1 || val2 !== e.v2 || dep1_busy !== e.b1 || dep2_busy !== e.b2 ||
          need_rob_id1 !== e.t1 || dep1_rob_id !== e.t1 ||
          need_rob_id2 !== e.t2 || dep2_rob_id !== e.t2) begin
        miscompares++;
        $display("FAIL %s: got val1=%h b1=%b need1=%h dep1id=%h val2=%h b2=%b need2=%h dep2id=%h; want val1=%h b1=%b id1=%h val2=%h b2=%b id2=%h",
                 e.name, val1, dep1_busy, need_rob_id1, dep1_rob_id, val2, dep2_busy,
                 need_rob_id2, dep2_rob_id, e.v1, e.b1, e.t1, e.v2, e.b2, e.t2);
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    cur = idle();
    cur.rst = 1'b0;
    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    commit_valid = 1'b0; commit_rd = '0; commit_val = '0; commit_rob_id = '0;
    dep_valid = 1'b0; dep_rd = '0; dep_rob_id = '0; rs1 = '0; rs2 = '0;
    rob_value1_ready = 1'b0; rob_value2_ready = 1'b0; rob_value1 = '0; rob_value2 = '0;

    s = idle(); s.rst = 1'b0; s.rs1 = 5'd5; s.rs2 = 5'd31; apply(s, "reset_state");
    s = idle(); s.rs1 = 5'd5; s.rs2 = 5'd31; apply(s, "after_reset");

    // dep then matching commit
    s = idle(); s.dv = 1; s.drd = 5; s.did = 3; apply(s, "s1_dep");
    s = idle(); s.rs1 = 5; apply(s, "s1_busy");
    s = idle(); s.cv = 1; s.crd = 5; s.cval = 32'hDEADBEEF; s.cid = 3; apply(s, "s1_commit");
    s = idle(); s.rs1 = 5; apply(s, "s1_done");

    // stale commit from an older writer keeps busy and the younger tag
    s = idle(); s.dv = 1; s.drd = 7; s.did = 2; apply(s, "s2_dep_a");
    s = idle(); s.dv = 1; s.drd = 7; s.did = 4; apply(s, "s2_dep_b");
    s = idle(); s.cv = 1; s.crd = 7; s.cid = 2; s.cval = 32'd11; s.rs1 = 7; apply(s, "s2_commit");
    s = idle(); s.rs1 = 7; apply(s, "s2_busy");
    s = idle(); s.clear = 1; apply(s, "s2_clear");
    s = idle(); s.rs1 = 7; apply(s, "s2_value");

    // same-cycle commit bypass
    s = idle(); s.dv = 1; s.drd = 9; s.did = 6; apply(s, "s3_dep");
    s = idle(); s.rs1 = 9; s.cv = 1; s.crd = 9; s.cid = 6; s.cval = 32'h55; apply(s, "s3_bypass");

    // ROB value forwarding
    s = idle(); s.dv = 1; s.drd = 3; s.did = 1; apply(s, "s4_dep");
    s = idle(); s.rs2 = 3; s.rr2 = 1; s.rv2 = 32'h1234; apply(s, "s4_rob");

    // clear vs. dep, x0 writes ignored
    s = idle(); s.dv = 1; s.drd = 4; s.did = 7; apply(s, "s5_dep4");
    s = idle(); s.dv = 1; s.drd = 8; s.did = 8; apply(s, "s5_dep8");
    s = idle(); s.clear = 1; s.dv = 1; s.drd = 10; s.did = 5; s.rs1 = 4; s.rs2 = 8; apply(s, "s5_clear");
    s = idle(); s.rs1 = 4; s.rs2 = 8; apply(s, "s5_after");
    s = idle(); s.rs1 = 10; s.cv = 1; s.crd = 0; s.cval = 7; s.dv = 1; s.drd = 0; s.did = 9; apply(s, "s5_x0");
    s = idle(); s.rs1 = 0; s.rs2 = 10; apply(s, "s5_x0_read");

    // same-rd commit and dep: value written, dep wins
    s = idle(); s.dv = 1; s.drd = 12; s.did = 2; apply(s, "s6_dep");
    s = idle(); s.cv = 1; s.crd = 12; s.cid = 2; s.cval = 32'hA5; s.dv = 1; s.drd = 12; s.did = 9; apply(s, "s6_both");
    s = idle(); s.rs1 = 12; s.rs2 = 12; s.rr2 = 1; s.rv2 = 32'h77; apply(s, "s6_read");

    // rdy low freezes state; async reset clears outputs mid-cycle
    s = idle(); s.rdy = 0; s.cv = 1; s.crd = 6; s.cval = 32'h66; s.cid = 0; s.dv = 1; s.drd = 6; s.did = 3; apply(s, "s7_stall");
    s = idle(); s.rs1 = 6; s.rs2 = 12; apply(s, "s7_frozen");
    s = idle(); s.rst = 0; s.rs1 = 12; s.rs2 = 5; s.cv = 1; s.crd = 5; s.cval = 32'h9; s.dv = 1; s.drd = 5; s.did = 1; apply(s, "s7_reset");
    s = idle(); s.rs1 = 12; s.rs2 = 5; apply(s, "s7_post");

    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      s.rdy   = ($urandom_range(0, 9) != 0);
      s.clear = ($urandom_range(0, 19) == 0);
      s.cv    = $urandom_range(0, 1);
      s.crd   = 5'($urandom_range(0, 11));
      s.cval  = $urandom;
      s.cid   = ($urandom_range(0, 1) != 0) ? m_tag[s.crd] : RB'($urandom);
      s.dv    = $urandom_range(0, 1);
      s.drd   = 5'($urandom_range(0, 11));
      s.did   = RB'($urandom);
      s.rs1   = 5'($urandom_range(0, 11));
      s.rs2   = 5'($urandom_range(0, 11));
      s.rr1   = ($urandom_range(0, 3) == 0);
      s.rr2   = ($urandom_range(0, 3) == 0);
      s.rv1   = $urandom;
      s.rv2   = $urandom;
      apply(s, "random");
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
